// File: rtl/run_ctrl.sv
// run_ctrl -- run/pause/step/halt sequencer for a pipelined core.
//
// Decides each cycle whether the pipeline may advance (go). Execution stops
// on a halt syscall, pauses on a pause syscall or a breakpoint hit, and can
// be single-stepped from a resume button. The button input is named `cont`
// because `continue` is a reserved word in SystemVerilog.
//
// Ports
//   clk          system clock, all state on rising edge
//   rst          synchronous active-high reset
//   cont         resume button level, already synchronous to clk
//   step_mode    1 = single-step, 0 = free run
//   bp_en        breakpoint enable
//   bp_addr      breakpoint byte address
//   pc           IF-stage program counter
//   syscall_wb   syscall present in WB
//   A_wb         syscall service code in WB
//   go           pipeline advance enable (combinational)
//   state        RUN=00 PAUSE=01 STEP=10 HALT=11
//   halted       state == HALT
//   paused       state == PAUSE
//   run_cycles   saturating count of go cycles
//   pause_count  wrapping count of RUN->PAUSE entries
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | free running, go=1 unless an event stops the pipe this cycle
// PAUSE | stopped, waiting for a resume-button rising edge
// STEP  | one advance cycle, then back to PAUSE
// HALT  | terminal, only rst leaves it

module run_ctrl #(
    parameter logic [31:0] HALT_CODE  = 32'h0000_000A,
    parameter logic [31:0] PAUSE_CODE = 32'h0000_0032
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cont,
    input  logic        step_mode,
    input  logic        bp_en,
    input  logic [11:0] bp_addr,
    input  logic [11:0] pc,
    input  logic        syscall_wb,
    input  logic [31:0] A_wb,
    output logic        go,
    output logic [1:0]  state,
    output logic        halted,
    output logic        paused,
    output logic [31:0] run_cycles,
    output logic [7:0]  pause_count
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        PAUSE = 2'b01,
        STEP  = 2'b10,
        HALT  = 2'b11
    } run_state_t;

    run_state_t state_q;
    run_state_t state_next;
    logic       cont_d;
    logic       resume_mask;
    logic       cont_edge;
    logic       halt_ev;
    logic       pause_ev;
    logic       bp_ev;

    assign cont_edge = cont & ~cont_d;
    assign halt_ev   = syscall_wb && (A_wb == HALT_CODE);
    // The mask lets the instruction that caused a pause (still sitting in WB
    // or still at the breakpoint PC) get past once after resuming.
    assign pause_ev  = syscall_wb && (A_wb == PAUSE_CODE) && !resume_mask;
    assign bp_ev     = bp_en && (pc == bp_addr) && !resume_mask;

    always_comb begin
        state_next = state_q;
        go         = 1'b0;
        unique case (state_q)
            RUN: begin
                if (halt_ev) begin
                    state_next = HALT;
                end else if (pause_ev || bp_ev) begin
                    state_next = PAUSE;
                end else begin
                    // step_mode raised while running: finish this cycle, then stop
                    go = 1'b1;
                    if (step_mode) begin
                        state_next = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (cont_edge) begin
                    state_next = step_mode ? STEP : RUN;
                end
            end
            STEP: begin
                if (halt_ev) begin
                    state_next = HALT;
                end else begin
                    go         = !(pause_ev || bp_ev);
                    state_next = PAUSE;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = RUN;
            end
        endcase
        if (rst) begin
            go = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= step_mode ? PAUSE : RUN;
            cont_d      <= 1'b0;
            resume_mask <= 1'b0;
            run_cycles  <= 32'd0;
            pause_count <= 8'd0;
        end else begin
            state_q <= state_next;
            cont_d  <= cont;

            if ((state_q == PAUSE) && (state_next != PAUSE)) begin
                resume_mask <= 1'b1;
            end else if (go) begin
                resume_mask <= 1'b0;
            end

            if (go && (run_cycles != 32'hFFFF_FFFF)) begin
                run_cycles <= run_cycles + 32'd1;
            end

            if ((state_q == RUN) && (state_next == PAUSE)) begin
                pause_count <= pause_count + 8'd1;
            end
        end
    end

    assign state  = state_q;
    assign halted = (state_q == HALT);
    assign paused = (state_q == PAUSE);

endmodule
